// File: rtl/stream_framer_if.sv
// AXI4-Stream style bundle shared by the framer's input and output sides.
// The master drives payload and valid; the slave answers with ready.
interface stream_framer_if #(
  parameter int TDATA_NUM_BYTES = 8
);
  logic [TDATA_NUM_BYTES*8-1:0] tdata;
  logic [4:0]                   tdest;
  logic [4:0]                   tid;
  logic [8:0]                   tkeep;
  logic [8:0]                   tstrb;
  logic [8:0]                   tuser;
  logic                         tlast;
  logic                         tvalid;
  logic                         tready;

  modport master (
    output tdata, tdest, tid, tkeep, tstrb, tuser, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tdest, tid, tkeep, tstrb, tuser, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/stream_framer.sv
// Cuts an input stream into frames of cfg_len beats, forcing tlast on the final beat,
// through a 2-entry skid buffer whose head register drives the output directly.
module stream_framer #(
  parameter int TDATA_NUM_BYTES = 8
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_areset,
  stream_framer_if.slave     in,
  stream_framer_if.master    out,
  input  logic [31:0]        cfg_len,
  input  logic               cfg_start,
  output logic               busy,
  output logic               done,
  output logic               short_err,
  output logic               len_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BEAT_W = TDATA_NUM_BYTES*8 + 38;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [31:0]         len_q_r;
  logic [31:0]         cnt_r;
  logic [1:0]          occ_r;
  logic [BEAT_W-1:0]   head_r;
  logic [BEAT_W-1:0]   skid_r;
  logic [BEAT_W-1:0]   beat_s;
  logic                push_s;
  logic                pop_s;
  logic                at_end_s;
  logic                last_s;
  logic                start_ok_s;
  logic                start_bad_s;
  logic                fin_s;
  logic                done_r;
  logic                short_err_r;
  logic                len_err_r;

  // Ready only while framing and the skid entry is still free.
  assign in.tready   = (state_r == RUN) && (occ_r != 2'd2);
  assign push_s      = in.tvalid & in.tready;
  assign out.tvalid  = (occ_r != 2'd0);
  assign pop_s       = out.tvalid & out.tready;
  assign at_end_s    = (cnt_r == (len_q_r - 32'd1));
  assign last_s      = at_end_s | in.tlast;
  assign beat_s      = {in.tdata, in.tdest, in.tid, in.tkeep, in.tstrb, in.tuser, last_s};
  assign start_ok_s  = (state_r == IDLE) && cfg_start && (cfg_len != 32'd0);
  assign start_bad_s = (state_r == IDLE) && cfg_start && (cfg_len == 32'd0);
  assign fin_s       = (state_r == DRAIN) && pop_s && out.tlast;

  assign {out.tdata, out.tdest, out.tid, out.tkeep, out.tstrb, out.tuser, out.tlast} = head_r;

  assign busy      = (state_r != IDLE);
  assign done      = done_r;
  assign short_err = short_err_r;
  assign len_err   = len_err_r;

  // State register.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: the terminating push leaves RUN, the downstream tlast leaves DRAIN.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_nxt_s = RUN;
        else            state_nxt_s = IDLE;
      end
      RUN: begin
        if (push_s && last_s) state_nxt_s = DRAIN;
        else                  state_nxt_s = RUN;
      end
      DRAIN: begin
        if (fin_s) state_nxt_s = IDLE;
        else       state_nxt_s = DRAIN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Frame length, beat counter and status flags.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      len_q_r     <= 32'd0;
      cnt_r       <= 32'd0;
      done_r      <= 1'b0;
      short_err_r <= 1'b0;
      len_err_r   <= 1'b0;
    end else begin
      done_r    <= fin_s;
      len_err_r <= start_bad_s;
      if (start_ok_s) begin
        len_q_r     <= cfg_len;
        cnt_r       <= 32'd0;
        short_err_r <= 1'b0;
      end else if (push_s) begin
        cnt_r <= cnt_r + 32'd1;
        if (in.tlast && !at_end_s) begin
          short_err_r <= 1'b1;
        end else begin
          short_err_r <= short_err_r;
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Skid buffer: head feeds the output, skid catches a beat when the head is stalled.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      occ_r  <= 2'd0;
      head_r <= '0;
      skid_r <= '0;
    end else begin
      case (occ_r)
        2'd0: begin
          if (push_s) begin
            head_r <= beat_s;
            occ_r  <= 2'd1;
          end else begin
            occ_r  <= 2'd0;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            head_r <= beat_s;
          end else if (push_s) begin
            skid_r <= beat_s;
            occ_r  <= 2'd2;
          end else if (pop_s) begin
            occ_r  <= 2'd0;
          end else begin
            occ_r  <= 2'd1;
          end
        end
        2'd2: begin
          if (pop_s) begin
            head_r <= skid_r;
            occ_r  <= 2'd1;
          end else begin
            occ_r  <= 2'd2;
          end
        end
        default: occ_r <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_framer.sv
// Directed bench for stream_framer: the driver queues expected beats, a negedge monitor
// pops and compares them, and also checks done timing, payload hold and ready bubbles.
module tb_stream_framer;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  dest;
    logic [4:0]  id;
    logic [8:0]  keep;
    logic [8:0]  strb;
    logic [8:0]  user;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cfg_len = 32'd0;
  logic        cfg_start = 1'b0;
  logic        busy, done, short_err, len_err;
  logic        rdy_fix = 1'b1;
  logic        rand_rdy = 1'b0;
  logic        rnd_rdy = 1'b1;
  logic        chk_ready_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  beat_t exp_q[$];

  stream_framer_if #(.TDATA_NUM_BYTES(8)) in_if ();
  stream_framer_if #(.TDATA_NUM_BYTES(8)) out_if ();

  stream_framer #(.TDATA_NUM_BYTES(8)) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .in            (in_if),
    .out           (out_if),
    .cfg_len       (cfg_len),
    .cfg_start     (cfg_start),
    .busy          (busy),
    .done          (done),
    .short_err     (short_err),
    .len_err       (len_err)
  );

  always #5 clk = ~clk;

  assign out_if.tready = rand_rdy ? rnd_rdy : rdy_fix;

  always @(posedge clk) begin
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input int base, input int i, input logic last);
    beat_t b;
    b.d    = {32'(base), 32'(i) ^ 32'h5A5A_0000};
    b.dest = 5'(i + base);
    b.id   = 5'(base);
    b.keep = 9'(9'h1FF >> i);
    b.strb = 9'(i * 37);
    b.user = 9'(base * 3 + i);
    b.last = last;
    return b;
  endfunction

  function automatic beat_t cur_out();
    beat_t b;
    b.d    = out_if.tdata;
    b.dest = out_if.tdest;
    b.id   = out_if.tid;
    b.keep = out_if.tkeep;
    b.strb = out_if.tstrb;
    b.user = out_if.tuser;
    b.last = out_if.tlast;
    return b;
  endfunction

  // Monitor: scoreboard pops, done timing, payload hold while stalled, ready bubbles.
  int    occ = 0;
  logic  pend_done = 1'b0;
  logic  exp_done = 1'b0;
  logic  stall = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    beat_t e;
    beat_t c;
    logic acc_in, acc_out;
    if (rst) begin
      occ = 0; pend_done = 1'b0; exp_done = 1'b0; stall = 1'b0;
    end else begin
      c       = cur_out();
      acc_in  = in_if.tvalid & in_if.tready;
      acc_out = out_if.tvalid & out_if.tready;
      exp_done  = pend_done;
      pend_done = 1'b0;
      if (stall) begin
        chk("hold_data", c.d, held.d);
        chk("hold_side", {c.dest, c.id, c.keep, c.strb, c.user, c.last},
            {held.dest, held.id, held.keep, held.strb, held.user, held.last});
      end
      if (exp_done || done) begin
        chk("done_pulse", 64'(done), 64'(exp_done));
        if (exp_done) chk("idle_at_done", 64'(busy), 64'd0);
      end
      if (chk_ready_en && in_if.tvalid && !in_if.tready) begin
        chk("bubble_only_full", 64'(occ), 64'd2);
      end
      if (acc_out) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_beat: got beat data %0h, required no beat", c.d);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", c.d, e.d);
          chk("beat_side", {c.dest, c.id, c.keep, c.strb, c.user, c.last},
              {e.dest, e.id, e.keep, e.strb, e.user, e.last});
        end
        if (c.last) pend_done = 1'b1;
      end
      occ   = occ + (acc_in ? 1 : 0) - (acc_out ? 1 : 0);
      stall = out_if.tvalid & ~out_if.tready;
      held  = c;
    end
  end

  task automatic drive(input beat_t b, input logic tl);
    in_if.tdata = b.d;    in_if.tdest = b.dest; in_if.tid = b.id;
    in_if.tkeep = b.keep; in_if.tstrb = b.strb; in_if.tuser = b.user;
    in_if.tlast = tl;
  endtask

  task automatic start(input logic [31:0] len);
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_len = len;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  // Offers n_offer beats; the first n_acc must be taken, the rest must be refused.
  task automatic send(input int base, input int n_offer, input int n_acc, input int tl_idx,
                      output int waits);
    logic acc;
    waits = 0;
    for (int i = 0; i < n_offer; i++) begin
      @(posedge clk); #1;
      drive(mk(base, i, 1'b0), 1'(i == tl_idx));
      in_if.tvalid = 1'b1;
      if (i < n_acc) begin
        acc = 1'b0;
        for (int c = 0; c < 60 && !acc; c++) begin
          @(negedge clk);
          if (in_if.tready) acc = 1'b1;
          else waits++;
        end
        if (!acc) begin
          n_tests++; n_fail++;
          $display("FAIL accept_timeout: beat %0d not accepted, required acceptance", i);
        end
      end else begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("refuse_extra", 64'(in_if.tready), 64'd0);
        end
      end
    end
    @(posedge clk); #1;
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic idle;
    idle = 1'b0;
    for (int c = 0; c < 200 && !idle; c++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) begin
      n_tests++; n_fail++;
      $display("FAIL %s_idle_timeout: busy stuck at 1, required 0", name);
    end
    @(negedge clk);
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int w;
    in_if.tvalid = 1'b0;
    drive(mk(0, 0, 1'b0), 1'b0);
    #1 rst = 1'b1;
    #2;
    chk("rst_tready", 64'(in_if.tready), 64'd0);
    chk("rst_tvalid", 64'(out_if.tvalid), 64'd0);
    chk("rst_tlast",  64'(out_if.tlast), 64'd0);
    chk("rst_flags",  64'({busy, done, short_err, len_err}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Basic 4-beat frame at full rate.
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, i, 1'(i == 3)));
    start(32'd4);
    chk("busy_after_start", 64'(busy), 64'd1);
    send(1, 4, 4, -1, w);
    chk("full_rate_waits", 64'(w), 64'd0);
    wait_idle("len4");

    // Source offers 5 beats, only 3 fit the frame.
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(2, i, 1'(i == 2)));
    start(32'd3);
    send(2, 5, 3, -1, w);
    wait_idle("len3");
    chk("len3_no_short", 64'(short_err), 64'd0);

    // Early in_tlast on beat 2 of 8.
    for (int i = 0; i < 2; i++) exp_q.push_back(mk(3, i, 1'(i == 1)));
    start(32'd8);
    send(3, 2, 2, 1, w);
    wait_idle("short");
    chk("short_err_set", 64'(short_err), 64'd1);

    // Zero-length start is rejected.
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_len = 32'd0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(negedge clk);
    chk("len_err_pulse", 64'(len_err), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);
    chk("len0_tready", 64'(in_if.tready), 64'd0);
    @(negedge clk);
    chk("len_err_clear", 64'(len_err), 64'd0);
    chk("short_err_sticky", 64'(short_err), 64'd1);

    // 6 beats with random downstream back-pressure.
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(4, i, 1'(i == 5)));
    rand_rdy = 1'b1;
    start(32'd6);
    chk("short_err_cleared", 64'(short_err), 64'd0);
    chk_ready_en = 1'b1;
    send(4, 6, 6, -1, w);
    chk_ready_en = 1'b0;
    wait_idle("rand");
    rand_rdy = 1'b0;

    // Reset mid-frame with beats held in the buffer.
    rdy_fix = 1'b0;
    start(32'd5);
    send(5, 2, 2, -1, w);
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_if.tvalid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 64'(out_if.tvalid), 64'd0);
    chk("mid_rst_tlast",  64'(out_if.tlast), 64'd0);
    chk("mid_rst_tready", 64'(in_if.tready), 64'd0);
    chk("mid_rst_flags",  64'({busy, done, short_err, len_err}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    rdy_fix = 1'b1;
    exp_q.push_back(mk(6, 0, 1'b1));
    start(32'd1);
    send(6, 1, 1, -1, w);
    wait_idle("len1");
    chk("len1_no_short", 64'(short_err), 64'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: run exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
